// File: rtl/ddc_tune_ctrl.sv
// Retune sequencer for the IF->baseband downconverter: owns the NCO tuning word,
// pulses NCO phase clear on each (re)tune and blanks output until the filters flush.
module ddc_tune_ctrl #(
  parameter int               FTW_W          = 32,
  parameter logic [FTW_W-1:0] DEFAULT_FTW    = 32'h4000_0000,
  parameter int               SETTLE_SAMPLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [FTW_W-1:0] cfg_ftw,
  input  logic             sample_stb,
  output logic [FTW_W-1:0] nco_ftw,
  output logic             nco_phase_clr,
  output logic             mix_en,
  output logic             out_valid,
  output logic             locked,
  output logic [7:0]       retune_cnt
);

  localparam int CNT_W = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_SAMPLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] settle_cnt_reg, settle_cnt_next;
  logic             accept;
  logic             retune_inc;

  assign cfg_ready = (state_reg != LOAD);
  assign accept    = cfg_valid & cfg_ready;

  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    retune_inc      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (en) state_next = LOAD;
      end
      LOAD: begin
        settle_cnt_next = SETTLE_INIT;
        state_next      = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
      end
      SETTLE: begin
        if (accept) begin
          state_next = LOAD;
          retune_inc = 1'b1;
        end else if (sample_stb) begin
          // count==1 is the last blanked strobe; <=1 also keeps a zero count from wrapping
          if (settle_cnt_reg <= CNT_W'(1)) begin
            settle_cnt_next = '0;
            state_next      = RUN;
          end else begin
            settle_cnt_next = settle_cnt_reg - CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (accept) begin
          state_next = LOAD;
          retune_inc = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Disable wins over any retune; a retune seen while dropping en is not counted
    if (!en) begin
      state_next = IDLE;
      retune_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= '0;
      nco_ftw        <= DEFAULT_FTW;
      nco_phase_clr  <= 1'b0;
      mix_en         <= 1'b0;
      locked         <= 1'b0;
      out_valid      <= 1'b0;
      retune_cnt     <= 8'd0;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      if (accept) nco_ftw <= cfg_ftw;
      // Status flags decode the next state so they line up with state_reg
      nco_phase_clr  <= (state_next == LOAD);
      mix_en         <= (state_next != IDLE);
      locked         <= (state_next == RUN);
      out_valid      <= sample_stb & (state_reg == RUN);
      if (retune_inc && (retune_cnt != 8'hFF)) retune_cnt <= retune_cnt + 8'd1;
    end
  end

endmodule
